// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder controller. It accepts an operand bundle {a, b, cin} and
//   then adds one bit per cycle, LSB first, through a single full-adder cell.
//   The carry is registered between cycles. The sum bits shift into a result
//   register from the top, so after WIDTH cycles bit 0 has reached bit 0.
//   Handshakes: the operand is taken in IDLE and the result is offered in DONE.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      ready for operands (IDLE only)
//   a, b       in   WIDTH  operands, sampled on the input handshake
//   cin        in   1      carry-in, sampled on the input handshake
//   out_valid  out  1      sum/cout valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-adder cell fed from the low bits of the shift registers.
  logic fa_s, fa_c;
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  // The new sum bit enters at the MSB. A one-bit adder has nothing to shift.
  logic [WIDTH-1:0] sum_shifted;
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shifted = fa_s;
    end else begin : g_sum_wn
      assign sum_shifted = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_shifted;
        carry_d = fa_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE never accepts input in the same cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // samples the pre-edge values. The reset is synchronous: it is only sampled
    // on the clock edge.
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // The handshake outputs are forced low while reset is asserted, even before an edge.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = rst_n && (state_q == DONE);
  assign busy      = rst_n && (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
